// File: rtl/jtag_dr_chain_sel.sv
// TAP data-register chain selector: registered chain select from IR,
// DR strobe routing, built-in BYPASS, registered TDO, shift counter.
// Ports:
//   tck, trst_n            TAP clock, async active-low reset
//   test_logic_reset       sync reset strobe from TAP controller
//   ir_value, update_ir    instruction and Update-IR strobe
//   capture_dr, shift_dr, update_dr, tdi, s_data_in   DR strobes / serial data
//   capture_dr_out, shift_dr_out, update_dr_out       per-chain enables
//   sel_idx, sel_valid, tdo, tdo_oe, shift_cnt, protocol_err  status / serial out
module jtag_dr_chain_sel #(
  parameter int N_CH = 8,
  parameter int IR_W = 4,
  parameter logic [N_CH*IR_W-1:0] CH_CODES =
    {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0},
  parameter int RST_CH = 0,
  parameter int CNT_W = 16,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic             test_logic_reset,
  input  logic [IR_W-1:0]  ir_value,
  input  logic             update_ir,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic             tdi,
  input  logic [N_CH-1:0]  s_data_in,
  output logic [N_CH-1:0]  capture_dr_out,
  output logic [N_CH-1:0]  shift_dr_out,
  output logic [N_CH-1:0]  update_dr_out,
  output logic [SEL_W-1:0] sel_idx,
  output logic             sel_valid,
  output logic             tdo,
  output logic             tdo_oe,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             protocol_err
);

  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RST_CH);

  logic cap;
  logic shf;
  logic upd;
  logic any_dr;
  logic multi_dr;
  logic ir_ok;
  logic ir_hit;
  logic [SEL_W-1:0] ir_idx;
  logic chain_so;

  // Priority capture > shift > update; the masked strobes drive
  // both the routed enables and the internal state.
  assign cap = capture_dr;
  assign shf = shift_dr & ~capture_dr;
  assign upd = update_dr & ~capture_dr & ~shift_dr;

  assign any_dr   = capture_dr | shift_dr | update_dr;
  assign multi_dr = (capture_dr & shift_dr)
                  | (capture_dr & update_dr)
                  | (shift_dr & update_dr);
  assign ir_ok    = update_ir & ~any_dr;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    ir_hit = 1'b0;
    ir_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (CH_CODES[i*IR_W +: IR_W] == ir_value) begin
        ir_hit = 1'b1;
        ir_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    capture_dr_out = '0;
    shift_dr_out   = '0;
    update_dr_out  = '0;
    chain_so       = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_valid && sel_idx == SEL_W'(i)) begin
        capture_dr_out[i] = cap;
        shift_dr_out[i]   = shf;
        update_dr_out[i]  = upd;
        chain_so          = s_data_in[i];
      end
    end
  end

  logic bypass_q;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sel_idx      <= RST_SEL;
      sel_valid    <= 1'b1;
      bypass_q     <= 1'b0;
      tdo          <= 1'b0;
      tdo_oe       <= 1'b0;
      shift_cnt    <= '0;
      protocol_err <= 1'b0;
    end else if (test_logic_reset) begin
      sel_idx      <= RST_SEL;
      sel_valid    <= 1'b1;
      bypass_q     <= 1'b0;
      tdo          <= 1'b0;
      tdo_oe       <= 1'b0;
      shift_cnt    <= '0;
      protocol_err <= 1'b0;
    end else begin
      tdo_oe <= shf;
      if (shf) begin
        tdo <= sel_valid ? chain_so : bypass_q;
      end
      if (cap) begin
        shift_cnt <= '0;
      end else if (shf && shift_cnt != '1) begin
        shift_cnt <= shift_cnt + CNT_W'(1);
      end
      if (!sel_valid) begin
        if (cap) begin
          bypass_q <= 1'b0;
        end else if (shf) begin
          bypass_q <= tdi;
        end
      end
      if (multi_dr || (update_ir && any_dr)) begin
        protocol_err <= 1'b1;
      end
      if (ir_ok) begin
        if (ir_hit) begin
          sel_idx   <= ir_idx;
          sel_valid <= 1'b1;
        end else begin
          sel_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_dr_chain_sel.sv
// Testbench for jtag_dr_chain_sel: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_jtag_dr_chain_sel;

  localparam int N_CH = 8;
  localparam int IR_W = 4;
  localparam int CNT_W = 4;
  localparam int SEL_W = 3;
  // Chain 6 duplicates code 2 so the lowest-index rule is exercised.
  localparam logic [N_CH*IR_W-1:0] CODES =
    {4'd7, 4'd2, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  logic             tck = 1'b0;
  logic             trst_n;
  logic             test_logic_reset;
  logic [IR_W-1:0]  ir_value;
  logic             update_ir;
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic             tdi;
  logic [N_CH-1:0]  s_data_in;
  logic [N_CH-1:0]  capture_dr_out;
  logic [N_CH-1:0]  shift_dr_out;
  logic [N_CH-1:0]  update_dr_out;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_valid;
  logic             tdo;
  logic             tdo_oe;
  logic [CNT_W-1:0] shift_cnt;
  logic             protocol_err;

  jtag_dr_chain_sel #(
    .N_CH(N_CH), .IR_W(IR_W), .CH_CODES(CODES),
    .RST_CH(0), .CNT_W(CNT_W)
  ) dut (
    .tck(tck), .trst_n(trst_n),
    .test_logic_reset(test_logic_reset),
    .ir_value(ir_value), .update_ir(update_ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .tdi(tdi), .s_data_in(s_data_in),
    .capture_dr_out(capture_dr_out), .shift_dr_out(shift_dr_out),
    .update_dr_out(update_dr_out), .sel_idx(sel_idx),
    .sel_valid(sel_valid), .tdo(tdo), .tdo_oe(tdo_oe),
    .shift_cnt(shift_cnt), .protocol_err(protocol_err)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int code_map[16];
  int m_sel;
  bit m_valid, m_byp, m_tdo, m_oe, m_err;
  int m_cnt;

  function automatic void m_reset();
    m_sel = 0; m_valid = 1; m_byp = 0;
    m_tdo = 0; m_oe = 0; m_cnt = 0; m_err = 0;
  endfunction

  initial begin
    logic [N_CH*IR_W-1:0] c;
    c = CODES;
    for (int k = 0; k < 16; k++) code_map[k] = -1;
    for (int i = N_CH - 1; i >= 0; i--)
      code_map[c[i*IR_W +: IR_W]] = i;
    m_reset();
  end

  initial begin
    forever begin
      @(posedge tck or negedge trst_n);
      if (!trst_n || test_logic_reset) begin
        m_reset();
      end else begin
        int n;
        bit c, s;
        n = int'(capture_dr) + int'(shift_dr) + int'(update_dr);
        c = capture_dr;
        s = shift_dr && !capture_dr;
        if (n > 1 || (update_ir && n > 0)) m_err = 1;
        if (s) m_tdo = m_valid ? s_data_in[m_sel] : m_byp;
        m_oe = s;
        if (c) m_cnt = 0;
        else if (s && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_valid) begin
          if (c) m_byp = 0;
          else if (s) m_byp = tdi;
        end
        if (update_ir && n == 0) begin
          if (code_map[ir_value] >= 0) begin
            m_sel = code_map[ir_value];
            m_valid = 1;
          end else begin
            m_valid = 0;
          end
        end
      end
    end
  end

  // Compare every cycle mid-period, away from the active edge.
  always @(negedge tck) begin
    if (run_cmp) begin
      logic [N_CH-1:0] oh, ec, es, eu;
      oh = m_valid ? N_CH'(1) << m_sel : '0;
      ec = capture_dr ? oh : '0;
      es = (shift_dr && !capture_dr) ? oh : '0;
      eu = (update_dr && !capture_dr && !shift_dr) ? oh : '0;
      chk("m_cap_en", 32'(capture_dr_out), 32'(ec));
      chk("m_shf_en", 32'(shift_dr_out), 32'(es));
      chk("m_upd_en", 32'(update_dr_out), 32'(eu));
      chk("m_sel_idx", 32'(sel_idx), 32'(m_sel));
      chk("m_sel_valid", 32'(sel_valid), 32'(m_valid));
      chk("m_tdo", 32'(tdo), 32'(m_tdo));
      chk("m_tdo_oe", 32'(tdo_oe), 32'(m_oe));
      chk("m_shift_cnt", 32'(shift_cnt), 32'(m_cnt));
      chk("m_protocol_err", 32'(protocol_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic idle_inputs();
    test_logic_reset = 0; ir_value = '0; update_ir = 0;
    capture_dr = 0; shift_dr = 0; update_dr = 0;
    tdi = 0; s_data_in = '0;
  endtask

  int seq5[5] = '{1, 0, 1, 1, 0};
  int tdi3[3] = '{1, 0, 1};
  int tdo3[3] = '{0, 1, 0};

  initial begin
    idle_inputs();
    trst_n = 0;
    repeat (2) tick();
    run_cmp = 1;
    chk("rst_sel_idx", 32'(sel_idx), 0);
    chk("rst_sel_valid", 32'(sel_valid), 1);
    chk("rst_tdo", 32'(tdo), 0);
    chk("rst_tdo_oe", 32'(tdo_oe), 0);
    chk("rst_cnt", 32'(shift_cnt), 0);
    chk("rst_err", 32'(protocol_err), 0);
    trst_n = 1;
    tick();
    shift_dr = 1;
    #1 chk("rst_shift_en", 32'(shift_dr_out), 32'h01);
    tick();
    shift_dr = 0;
    chk("rst_tdo_oe_next", 32'(tdo_oe), 1);

    // chain 3 selection and scan
    ir_value = 4'h3; update_ir = 1;
    tick();
    update_ir = 0;
    chk("sel3_idx", 32'(sel_idx), 3);
    capture_dr = 1;
    #1 chk("sel3_cap_en", 32'(capture_dr_out), 32'h08);
    tick();
    capture_dr = 0;
    chk("sel3_cnt0", 32'(shift_cnt), 0);
    for (int k = 0; k < 5; k++) begin
      shift_dr = 1;
      s_data_in = N_CH'($urandom) & ~N_CH'(8);
      s_data_in[3] = seq5[k][0];
      #1 chk("sel3_shf_en", 32'(shift_dr_out), 32'h08);
      tick();
      chk("sel3_tdo", 32'(tdo), 32'(seq5[k]));
    end
    shift_dr = 0;
    chk("sel3_cnt5", 32'(shift_cnt), 5);
    update_dr = 1;
    #1 chk("sel3_upd_en", 32'(update_dr_out), 32'h08);
    tick();
    update_dr = 0;

    // unmapped instruction -> bypass
    ir_value = 4'hF; update_ir = 1;
    tick();
    update_ir = 0;
    chk("byp_valid", 32'(sel_valid), 0);
    capture_dr = 1;
    #1 chk("byp_cap_en", 32'(capture_dr_out), 0);
    tick();
    capture_dr = 0;
    for (int k = 0; k < 3; k++) begin
      shift_dr = 1;
      tdi = tdi3[k][0];
      s_data_in = '1;
      #1 chk("byp_shf_en", 32'(shift_dr_out), 0);
      tick();
      chk("byp_tdo", 32'(tdo), 32'(tdo3[k]));
    end
    shift_dr = 0; tdi = 0;

    // strobe overlap with code 2 (lowest of duplicate -> chain 2)
    ir_value = 4'h2; update_ir = 1;
    tick();
    update_ir = 0;
    chk("ovl_sel_idx", 32'(sel_idx), 2);
    capture_dr = 1; shift_dr = 1;
    #1 chk("ovl_cap_en", 32'(capture_dr_out), 32'h04);
    chk("ovl_shf_en", 32'(shift_dr_out), 0);
    tick();
    capture_dr = 0; shift_dr = 0;
    chk("ovl_err", 32'(protocol_err), 1);
    repeat (3) tick();
    chk("ovl_err_sticky", 32'(protocol_err), 1);
    test_logic_reset = 1;
    tick();
    test_logic_reset = 0;
    chk("tlr_err", 32'(protocol_err), 0);
    chk("tlr_sel_idx", 32'(sel_idx), 0);

    // counter saturation
    capture_dr = 1;
    tick();
    capture_dr = 0; shift_dr = 1;
    repeat (20) tick();
    shift_dr = 0;
    chk("sat_cnt", 32'(shift_cnt), 15);
    capture_dr = 1;
    tick();
    capture_dr = 0;
    chk("sat_clear", 32'(shift_cnt), 0);

    // blocked update_ir, then async reset mid-shift
    ir_value = 4'h5; update_ir = 1;
    tick();
    chk("blk_sel5", 32'(sel_idx), 5);
    ir_value = 4'h2; shift_dr = 1; s_data_in = '1;
    tick();
    chk("blk_sel_held", 32'(sel_idx), 5);
    chk("blk_err", 32'(protocol_err), 1);
    chk("blk_tdo", 32'(tdo), 1);
    chk("blk_tdo_oe", 32'(tdo_oe), 1);
    #2 trst_n = 0;
    #1 chk("ar_tdo", 32'(tdo), 0);
    chk("ar_tdo_oe", 32'(tdo_oe), 0);
    chk("ar_sel_idx", 32'(sel_idx), 0);
    chk("ar_shf_en", 32'(shift_dr_out), 32'h01);
    idle_inputs();
    tick();
    trst_n = 1;
    tick();

    // randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      capture_dr = 0; shift_dr = 0; update_dr = 0;
      if (r < 25) begin
      end else if (r < 42) capture_dr = 1;
      else if (r < 80) shift_dr = 1;
      else if (r < 92) update_dr = 1;
      else {capture_dr, shift_dr, update_dr} = 3'($urandom);
      update_ir = ($urandom_range(0, 7) == 0);
      ir_value = 4'($urandom);
      tdi = 1'($urandom);
      s_data_in = N_CH'($urandom);
      test_logic_reset = ($urandom_range(0, 99) == 0);
      trst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    idle_inputs();
    trst_n = 1;
    tick();
    run_cmp = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_dr_chain_sel.md
Name: jtag_dr_chain_sel

Overview:
- Parametrised successor to the fixed 8-way TAP data-register mux.
- Holds a registered chain selection, loaded from the instruction register on Update-IR, and routes DR strobes (capture/shift/update) to N_CH data-register chains.
- Provides a built-in 1-bit BYPASS register for unmapped instruction codes, a registered TDO with output enable, a shift-length counter and a sticky protocol-error flag.
- Sits between the TAP controller state decode and the per-chain registers (IDCODE, IMPCODE, ADDRESS, DATA, CONTROL, …).

Parameters:
- N_CH, 8, number of DR chains (1..16).
- IR_W, 4, instruction register width.
- CH_CODES, {4'd7,4'd6,4'd5,4'd4,4'd3,4'd2,4'd1,4'd0}, packed N_CH*IR_W instruction codes; slice i selects chain i.
- RST_CH, 0, chain index selected after reset / Test-Logic-Reset (IDCODE).
- CNT_W, 16, shift counter width.

Ports:
- tck  in  1  TAP clock; all state updates on rising edge.
- trst_n  in  1  asynchronous active-low reset.
- test_logic_reset  in  1  synchronous reset strobe from the TAP controller.
- ir_value  in  IR_W  current instruction register contents.
- update_ir  in  1  Update-IR state strobe.
- capture_dr  in  1  Capture-DR state strobe.
- shift_dr  in  1  Shift-DR state strobe.
- update_dr  in  1  Update-DR state strobe.
- tdi  in  1  serial data in.
- s_data_in  in  N_CH  serial out bit (LSB) of each chain.
- capture_dr_out  out  N_CH  per-chain capture enable.
- shift_dr_out  out  N_CH  per-chain shift enable.
- update_dr_out  out  N_CH  per-chain update enable.
- sel_idx  out  $clog2(N_CH) (min 1)  registered selected chain index.
- sel_valid  out  1  1 = mapped chain selected; 0 = internal BYPASS.
- tdo  out  1  registered serial out.
- tdo_oe  out  1  TDO output enable.
- shift_cnt  out  CNT_W  shift cycles since last capture.
- protocol_err  out  1  sticky strobe-overlap error.

Behaviour:
- Reset (trst_n=0, async) and test_logic_reset (sync) both force: sel_idx=RST_CH, sel_valid=1, bypass_q=0, tdo=0, tdo_oe=0, shift_cnt=0, protocol_err=0.
- Selection on an accepted update_ir:
  - Choose the lowest index i with CH_CODES[i]==ir_value; set sel_idx=i, sel_valid=1.
  - If no code matches: sel_valid=0, sel_idx unchanged.
  - New selection is visible the cycle after the update_ir edge.
  - Selection otherwise holds; it never changes between capture_dr and update_dr.
- update_ir asserted together with any DR strobe: ignored (selection held) and protocol_err set.
- Strobe routing:
  - Combinational, zero latency: X_out[i] = X & sel_valid & (sel_idx==i) for capture, shift and update.
  - All enables are 0 when sel_valid=0.
  - Outputs are enables, not gated clocks.
- Strobe priority:
  - More than one of capture_dr/shift_dr/update_dr high in one cycle sets protocol_err.
  - Priority is capture > shift > update: only the highest-priority enable is routed; lower ones are masked.
- BYPASS register:
  - capture_dr & !sel_valid: bypass_q <= 0.
  - shift_dr & !sel_valid: bypass_q <= tdi.
- TDO:
  - Each cycle, tdo_oe <= shift_dr.
  - On a shift_dr cycle, tdo <= (sel_valid ? s_data_in[sel_idx] : bypass_q), sampled before the shift edge.
  - Otherwise tdo holds.
  - This fixed one-cycle latency is compensated at the TAP top level.
- shift_cnt:
  - Cleared to 0 on capture_dr.
  - +1 per shift_dr cycle; saturates at 2^CNT_W-1 with no wrap.
  - Holds through update_dr and idle.
- protocol_err is cleared only by trst_n or test_logic_reset.
- Asynchronous reset in the middle of a scan: all state and outputs take reset values immediately; combinational enables re-derive from RST_CH.

Test Plan:
- Reset sequence:
  - Stimulus: trst_n low, then high; pulse shift_dr.
  - Required: sel_idx=0, sel_valid=1, shift_dr_out=8'h01, tdo_oe=1 the next cycle.
- Chain selection and scan:
  - Stimulus: update_ir with ir_value=4'h3; then capture, then 5 shift cycles with s_data_in[3] toggling 1,0,1,1,0.
  - Required: only bit 3 enabled on capture/shift/update; tdo sequence 1,0,1,1,0 at one-cycle lag; shift_cnt=5.
- Unmapped instruction (BYPASS path):
  - Stimulus: update_ir with ir_value=4'hF; capture, then shift tdi=1,0,1.
  - Required: sel_valid=0; all enables 0; tdo sequence 0,1,0 (bypass delay).
- Strobe overlap:
  - Stimulus: capture_dr and shift_dr high together with chain 2 selected.
  - Required: capture_dr_out=8'h04, shift_dr_out=0, protocol_err=1 sticky until test_logic_reset.
- Counter saturation:
  - Stimulus: CNT_W=4; shift 20 cycles.
  - Required: shift_cnt stops at 15; a following capture_dr clears it to 0.
- Blocked update_ir and async reset mid-scan:
  - Stimulus: update_ir high together with shift_dr → selection unchanged, protocol_err=1; then assert trst_n mid-shift.
  - Required: tdo=0, tdo_oe=0, sel_idx=0 immediately.
